imem_fetch_port: RTL
====================

Name: imem_fetch_port

Overview:
Parametrised instruction memory with a valid/ready fetch interface.
- Byte-addressed with word-aligned fetch, configurable read wait states and alignment/range fault reporting.
- A program-load write port fills the array at run time.
- Sits between the IF stage PC register and the IF/ID pipeline register. Stalls propagate through the handshakes.

Parameters:
DATA_W, 32, instruction word width in bits
ADDR_W, 32, byte-address width of req_addr
DEPTH, 1024, number of words in the array (power of two)
WAIT_CYCLES, 0, extra read wait states, 0..15

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  fetch request valid
req_ready  out  1  fetch request accepted when high with req_valid
req_addr  in  ADDR_W  byte address of instruction
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_data  out  DATA_W  fetched instruction
rsp_fault  out  1  misaligned or out-of-range fetch
prog_we  in  1  program-load write enable
prog_addr  in  $clog2(DEPTH)  word index for write
prog_data  in  DATA_W  word to write
busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset (async, rst=1): state IDLE, rsp_valid=0, rsp_data=0, rsp_fault=0, wait counter=0, busy=0. Array contents are not reset.
- Reset mid-transaction drops the in-flight fetch with no response.
- Index = req_addr[$clog2(DEPTH)+1:2].
- Fault = (req_addr[1:0]!=0) or (req_addr>>2 >= DEPTH). On fault, rsp_data=0 and rsp_fault=1. Latency is the same as a normal fetch.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1.
  - On req_valid, capture index and fault, load counter=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT: req_ready=0. Counter decrements each cycle. At counter==1, go to RESP.
- Array read is registered and sampled on the transition into RESP.
- Accept-to-rsp_valid latency is exactly 1+WAIT_CYCLES cycles.
- RESP: rsp_valid=1. rsp_data and rsp_fault are held stable until rsp_ready=1.
  - req_ready=rsp_ready, so a new request can be accepted in the same cycle as the response handshake.
  - Handshake with a new request: start the new fetch; with WAIT_CYCLES=0, stay in RESP with the new data next cycle.
  - Handshake with no new request: go to IDLE and drop rsp_valid.
- Throughput: 1 fetch/cycle when WAIT_CYCLES=0; otherwise 1 per 1+WAIT_CYCLES cycles.
- prog_we writes prog_data into array[prog_addr] at the clock edge, independent of FSM state.
- Write and sampling read to the same index in the same cycle: the read returns the old word (read-before-write).
- req_addr is ignored unless accepted. Changing it while req_valid=0 has no effect.

Optional Feature:
IMEM_PARITY_EN
- Defined: each word stores an extra even-parity bit, computed on prog writes.
  - On read, recomputed parity is checked. A mismatch sets rsp_fault=1 and forces rsp_data=0.
  - An extra input port, par_inject (1 bit), flips the stored parity bit on a write, for test.
- Undefined: no parity storage, no par_inject port. rsp_fault reflects alignment/range only.

Test Plan:
- Load: prog writes 0x00000013 to idx0 and 0x40628333 to idx1. Fetch addr 0x0 then 0x4, WAIT_CYCLES=0, rsp_ready=1 -> rsp_valid each cycle after accept, data 0x00000013 then 0x40628333, fault=0.
- Misaligned: fetch 0x6 -> after 1+WAIT_CYCLES cycles rsp_valid=1, rsp_fault=1, rsp_data=0. Fetch 0x1000 with DEPTH=1024 -> rsp_fault=1.
- Backpressure: WAIT_CYCLES=3, fetch 0x4, rsp_ready=0 for 5 cycles -> rsp_valid asserts 4 cycles after accept, data stable and req_ready=0 until rsp_ready=1.
- Collision: in-flight fetch of idx2 (old 0xAAAA5555) with prog write 0x12345678 to idx2 on the sample cycle -> response 0xAAAA5555. Refetch -> 0x12345678.
- Reset mid-op: assert rst during WAIT -> rsp_valid, busy, rsp_data immediately 0. No response after rst release. Next fetch completes normally.
- Parity (IMEM_PARITY_EN): write idx3 with par_inject=1, fetch 0xC -> rsp_fault=1, rsp_data=0.

Source files
------------

// File: rtl/imem_fetch_port.sv
// Instruction memory with a valid/ready fetch port, optional read wait states and a program-load write port.
// Define IMEM_PARITY_EN to store a per-word even-parity bit and flag parity errors as fetch faults.
module imem_fetch_port #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_fault,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [DATA_W-1:0]        prog_data,
`ifdef IMEM_PARITY_EN
  input  logic                     par_inject,
`endif
  output logic                     busy
);

  localparam int IDX_W = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_fault_q, rsp_fault_d;

  logic [MEM_W-1:0]  mem [DEPTH];

  logic [IDX_W-1:0]  req_idx, rd_idx;
  logic              req_fault, rd_fault, rd_bad;
  logic              start, load_rsp;
  logic [MEM_W-1:0]  rd_word;

  assign req_idx   = req_addr[IDX_W+1:2];
  assign req_fault = (req_addr[1:0] != 2'b00) || (req_addr[ADDR_W-1:IDX_W+2] != '0);

  // A response slot frees up in the same cycle the consumer takes the current one.
  assign req_ready = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rsp_data  = rsp_data_q;
  assign rsp_fault = rsp_fault_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    fault_d  = fault_q;
    rd_idx   = idx_q;
    rd_fault = fault_q;
    start    = 1'b0;
    load_rsp = 1'b0;

    case (state_q)
      S_IDLE: start = req_valid;
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d  = S_RESP;
          load_rsp = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          start   = req_valid;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // With no wait states the array is sampled on the accept edge, straight from the request.
    if (start) begin
      idx_d   = req_idx;
      fault_d = req_fault;
      cnt_d   = WAIT_LD;
      if (WAIT_CYCLES > 0) begin
        state_d = S_WAIT;
      end else begin
        state_d  = S_RESP;
        load_rsp = 1'b1;
        rd_idx   = req_idx;
        rd_fault = req_fault;
      end
    end
  end

  assign rd_word = mem[rd_idx];

`ifdef IMEM_PARITY_EN
  assign rd_bad = rd_fault || ((^rd_word[DATA_W-1:0]) != rd_word[DATA_W]);
`else
  assign rd_bad = rd_fault;
`endif

  always_comb begin
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
    if (load_rsp) begin
      rsp_data_d  = rd_bad ? '0 : rd_word[DATA_W-1:0];
      rsp_fault_d = rd_bad;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rsp_data_q  <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    fault_q <= fault_d;
  end

  // Same-edge write and sampling read of one word returns the old contents.
  always_ff @(posedge clk) begin
    if (prog_we) begin
`ifdef IMEM_PARITY_EN
      mem[prog_addr] <= {(^prog_data) ^ par_inject, prog_data};
`else
      mem[prog_addr] <= prog_data;
`endif
    end
  end

endmodule
